switch_allocator: RTL and testbench

//  Router-level switch allocator for the N ports of one router. Each input port raises a route

---
 rtl/switch_allocator_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 33 +++
 rtl/switch_allocator.sv | 133 +++++++++++++
 tb/tb_switch_allocator.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/switch_allocator_pkg.sv
// Shared definitions for the switch allocator: per-output FSM encoding and
// slice helpers for the flattened per-port buses.
package switch_allocator_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } out_state_e;

    // Low bit of element idx in a bus packed as idx*width +: width.
    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches req_i starting at ptr_i, wrapping modulo N,
// and returns the first requester as a one-hot grant plus its binary index.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] gnt_idx_o
);

    always_comb begin
        int  cand;
        logic found;
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        cand      = 0;
        for (int k = 0; k < N; k++) begin
            cand = int'(ptr_i) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!found && req_i[cand]) begin
                found        = 1'b1;
                gnt_o[cand]  = 1'b1;
                gnt_idx_o    = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/switch_allocator.sv
// Router switch allocator: one round-robin arbiter and lock FSM per output.
// Optional lock-hold timeout enabled by defining SWITCH_ALLOC_TIMEOUT_EN.
module switch_allocator
    import switch_allocator_pkg::*;
#(
    parameter int N              = 4,
    parameter int REQUEST_WIDTH  = 2,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N-1:0]               routeReserveRequestValid,
    input  logic [N*REQUEST_WIDTH-1:0] routeReserveRequest,
    input  logic [N-1:0]               routeRelieve,
    output logic [N-1:0]               routeReserveStatus,
    output logic [N-1:0]               outLocked,
    output logic [N*REQUEST_WIDTH-1:0] outSelect
);

    localparam int RW = REQUEST_WIDTH;

    // An input owns an output when some locked output selects it; owners may not bid again.
    logic [N-1:0] owns;

    always_comb begin
        owns = '0;
        for (int o = 0; o < N; o++) begin
            for (int i = 0; i < N; i++) begin
                if (outLocked[o] && (outSelect[slice_lo(o, RW) +: RW] == RW'(i))) begin
                    owns[i] = 1'b1;
                end
            end
        end
    end

    assign routeReserveStatus = owns;

    for (genvar o = 0; o < N; o++) begin : g_out
        out_state_e     state_q;
        logic [RW-1:0]  sel_q;
        logic [RW-1:0]  ptr_q;
        logic [N-1:0]   cand;
        logic [N-1:0]   gnt;
        logic [RW-1:0]  win_idx;
        logic           owner_relieve;

        always_comb begin
            cand          = '0;
            owner_relieve = 1'b0;
            for (int i = 0; i < N; i++) begin
                cand[i] = routeReserveRequestValid[i]
                          && (routeReserveRequest[slice_lo(i, RW) +: RW] == RW'(o))
                          && !owns[i];
                if (sel_q == RW'(i)) begin
                    owner_relieve = routeRelieve[i];
                end
            end
        end

        rr_arbiter #(
            .N     (N),
            .IDX_W (RW)
        ) u_arb (
            .req_i     (cand),
            .ptr_i     (ptr_q),
            .gnt_o     (gnt),
            .gnt_idx_o (win_idx)
        );

`ifdef SWITCH_ALLOC_TIMEOUT_EN
        localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
        logic [CNT_W-1:0] hold_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                state_q <= ST_IDLE;
                sel_q   <= '0;
                ptr_q   <= '0;
                hold_q  <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (|gnt) begin
                            state_q <= ST_LOCKED;
                            sel_q   <= win_idx;
                            ptr_q   <= (win_idx == RW'(N - 1)) ? '0 : win_idx + 1'b1;
                            hold_q  <= '0;
                        end
                    end
                    ST_LOCKED: begin
                        // A stale lock is released exactly as an owner relieve would be.
                        if (owner_relieve || (hold_q == CNT_W'(TIMEOUT_CYCLES - 1))) begin
                            state_q <= ST_IDLE;
                        end else begin
                            hold_q <= hold_q + 1'b1;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
`else
        always_ff @(posedge clk) begin
            if (rst) begin
                state_q <= ST_IDLE;
                sel_q   <= '0;
                ptr_q   <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (|gnt) begin
                            state_q <= ST_LOCKED;
                            sel_q   <= win_idx;
                            ptr_q   <= (win_idx == RW'(N - 1)) ? '0 : win_idx + 1'b1;
                        end
                    end
                    ST_LOCKED: begin
                        if (owner_relieve) begin
                            state_q <= ST_IDLE;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
`endif

        // sel_q keeps the last owner while idle; consumers qualify it with outLocked.
        assign outLocked[o]              = (state_q == ST_LOCKED);
        assign outSelect[o*RW +: RW]     = sel_q;
    end

endmodule

// File: tb/tb_switch_allocator.sv
// Self-checking bench for switch_allocator: directed scenarios plus randomized traffic
// checked every cycle against an ownership-table reference model.
module tb_switch_allocator;

    localparam int N  = 4;
    localparam int RW = 2;
    localparam int TO = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     valid;
    logic [N*RW-1:0]  req;
    logic [N-1:0]     relieve;
    logic [N-1:0]     status;
    logic [N-1:0]     locked;
    logic [N*RW-1:0]  sel;

    logic [2:0]       valid3;
    logic [5:0]       req3;
    logic [2:0]       relieve3;
    logic [2:0]       status3;
    logic [2:0]       locked3;
    logic [5:0]       sel3;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: who owns each output (-1 = free), last owner, RR start, lock age.
    int m_owner [N];
    int m_last  [N];
    int m_ptr   [N];
    int m_age   [N];

    always #5 clk = ~clk;

    switch_allocator #(
        .N              (N),
        .REQUEST_WIDTH  (RW),
        .TIMEOUT_CYCLES (TO)
    ) u_dut (
        .clk                      (clk),
        .rst                      (rst),
        .routeReserveRequestValid (valid),
        .routeReserveRequest      (req),
        .routeRelieve             (relieve),
        .routeReserveStatus       (status),
        .outLocked                (locked),
        .outSelect                (sel)
    );

    switch_allocator #(
        .N              (3),
        .REQUEST_WIDTH  (2),
        .TIMEOUT_CYCLES (TO)
    ) u_dut3 (
        .clk                      (clk),
        .rst                      (rst),
        .routeReserveRequestValid (valid3),
        .routeReserveRequest      (req3),
        .routeRelieve             (relieve3),
        .routeReserveStatus       (status3),
        .outLocked                (locked3),
        .outSelect                (sel3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic model_holds(input int i);
        for (int o = 0; o < N; o++) begin
            if (m_owner[o] == i) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_step();
        logic [N-1:0] held;
        int dest;
        int c;
        if (rst) begin
            for (int o = 0; o < N; o++) begin
                m_owner[o] = -1;
                m_last[o]  = 0;
                m_ptr[o]   = 0;
                m_age[o]   = 0;
            end
            return;
        end
        for (int i = 0; i < N; i++) held[i] = model_holds(i);
        for (int o = 0; o < N; o++) begin
            if (m_owner[o] >= 0) begin
                if (relieve[m_owner[o]]) begin
                    m_owner[o] = -1;
                end
`ifdef SWITCH_ALLOC_TIMEOUT_EN
                else if (m_age[o] == TO - 1) begin
                    m_owner[o] = -1;
                end
`endif
                else begin
                    m_age[o]++;
                end
            end else begin
                for (int k = 0; k < N; k++) begin
                    c    = (m_ptr[o] + k) % N;
                    dest = int'(req[c*RW +: RW]);
                    if (m_owner[o] < 0 && valid[c] && dest == o && !held[c]) begin
                        m_owner[o] = c;
                        m_last[o]  = c;
                        m_ptr[o]   = (c + 1) % N;
                        m_age[o]   = 0;
                    end
                end
            end
        end
    endtask

    task automatic check_model(input string tag);
        logic [N-1:0]    exp_status;
        logic [N-1:0]    exp_locked;
        logic [N*RW-1:0] exp_sel;
        exp_status = '0;
        exp_locked = '0;
        exp_sel    = '0;
        for (int o = 0; o < N; o++) begin
            exp_locked[o]         = (m_owner[o] >= 0);
            exp_sel[o*RW +: RW]   = RW'(m_last[o]);
            if (m_owner[o] >= 0) exp_status[m_owner[o]] = 1'b1;
        end
        check({tag, "_status"}, 32'(status), 32'(exp_status));
        check({tag, "_locked"}, 32'(locked), 32'(exp_locked));
        check({tag, "_select"}, 32'(sel),    32'(exp_sel));
    endtask

    // One clock: inputs already applied; model advances on the edge, outputs checked #1 later.
    task automatic cycle(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_model(tag);
    endtask

    task automatic set_req(input int i, input int dest);
        valid[i]         = 1'b1;
        req[i*RW +: RW]  = RW'(dest);
    endtask

    task automatic clear_inputs();
        valid   = '0;
        req     = '0;
        relieve = '0;
    endtask

    initial begin
        int r;
        rst      = 1'b1;
        clear_inputs();
        valid3   = 3'b011;
        req3     = {2'd0, 2'd2, 2'd3};
        relieve3 = '0;

        // Reset with requests pending: everything held at zero.
        set_req(0, 0);
        set_req(1, 1);
        cycle("rst");
        cycle("rst");
        check("rst_status", 32'(status), 32'h0);
        check("rst_select", 32'(sel), 32'h0);
        rst = 1'b0;
        cycle("rst_rel");
        check("rst_rel_status", 32'(status), 32'b0011);
        clear_inputs();
        relieve = 4'b0011;
        cycle("rst_clr");
        relieve = '0;
        cycle("rst_clr");

        // Single request: input 1 -> output 3, relieve at t+5.
        set_req(1, 3);
        cycle("single");
        check("single_status", 32'(status[1]), 32'd1);
        check("single_locked", 32'(locked[3]), 32'd1);
        check("single_select", 32'(sel[7:6]), 32'd1);
        valid = '0;
        for (int k = 0; k < 4; k++) cycle("single_hold");
        check("single_held", 32'(locked[3]), 32'd1);
        relieve[1] = 1'b1;
        cycle("single_rel");
        relieve = '0;
        check("single_rel_status", 32'(status[1]), 32'd0);
        check("single_rel_locked", 32'(locked[3]), 32'd0);

        // Contention on output 1 from a fresh pointer.
        rst = 1'b1;
        cycle("cont_rst");
        rst = 1'b0;
        set_req(0, 1);
        set_req(2, 1);
        set_req(3, 1);
        cycle("cont");
        check("cont_first", 32'(sel[3:2]), 32'd0);
        valid[0] = 1'b0;
        relieve[0] = 1'b1;
        cycle("cont");
        check("cont_bubble1", 32'(locked[1]), 32'd0);
        relieve = '0;
        cycle("cont");
        check("cont_second", 32'(sel[3:2]), 32'd2);
        check("cont_second_lock", 32'(locked[1]), 32'd1);
        valid[2] = 1'b0;
        relieve[2] = 1'b1;
        cycle("cont");
        check("cont_bubble2", 32'(locked[1]), 32'd0);
        relieve = '0;
        cycle("cont");
        check("cont_third", 32'(sel[3:2]), 32'd3);
        valid[3] = 1'b0;
        relieve[3] = 1'b1;
        cycle("cont");
        relieve = '0;
        set_req(0, 1);
        set_req(2, 1);
        cycle("cont_ptr");
        check("cont_ptr_wrap", 32'(sel[3:2]), 32'd0);
        clear_inputs();
        relieve[0] = 1'b1;
        cycle("cont_clr");
        relieve = '0;

        // Parallel grants on different outputs.
        set_req(0, 2);
        set_req(1, 3);
        cycle("par");
        check("par_status", 32'(status), 32'b0011);
        check("par_locked", 32'(locked), 32'b1100);
        clear_inputs();
        relieve = 4'b0011;
        cycle("par_clr");
        relieve = '0;

        // Spurious relieve from non-owners leaves the lock in place.
        set_req(2, 0);
        cycle("spur");
        valid = '0;
        relieve = 4'b1010;
        cycle("spur");
        check("spur_locked", 32'(locked[0]), 32'd1);
        check("spur_select", 32'(sel[1:0]), 32'd2);
        relieve = 4'b0100;
        cycle("spur_clr");
        relieve = '0;
        check("spur_clr_locked", 32'(locked[0]), 32'd0);

        // N=3 instance: out-of-range request from input 0 never granted; input 1 -> out 2 is.
        check("ill_status", 32'(status3), 32'b010);
        check("ill_locked", 32'(locked3), 32'b100);
        check("ill_select", 32'(sel3[5:4]), 32'd1);

        // Lock hold limit.
        set_req(0, 0);
        cycle("hold");
        valid = '0;
`ifdef SWITCH_ALLOC_TIMEOUT_EN
        for (int k = 0; k < TO - 1; k++) cycle("tmo");
        check("tmo_last_locked", 32'(locked[0]), 32'd1);
        cycle("tmo");
        check("tmo_dropped", 32'(locked[0]), 32'd0);
`else
        for (int k = 0; k < 1000; k++) cycle("persist");
        check("persist_locked", 32'(locked[0]), 32'd1);
        relieve[0] = 1'b1;
        cycle("persist_clr");
        relieve = '0;
`endif

        // Randomized traffic with requester protocol, spurious relieves and rare resets.
        for (int n = 0; n < 3000; n++) begin
            rst     = ($urandom_range(0, 499) == 0);
            relieve = '0;
            for (int i = 0; i < N; i++) begin
                if (model_holds(i)) begin
                    valid[i]   = 1'b0;
                    relieve[i] = ($urandom_range(0, 3) == 0);
                end else begin
                    relieve[i] = ($urandom_range(0, 9) == 0);
                    if (valid[i]) begin
                        if ($urandom_range(0, 15) == 0) valid[i] = 1'b0;
                    end else if ($urandom_range(0, 2) == 0) begin
                        r = $urandom_range(0, N - 1);
                        set_req(i, r);
                    end
                end
            end
            cycle("rand");
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
